// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: dmem wait FSM states and the x0 register index.
// Latency: n/a (types only); backpressure: n/a.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } mem_st_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Latency: count updates the cycle after en; backpressure: none, en sampled every cycle.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/bubble sequencer: load-use, taken-branch and dmem-wait hazards plus perf counters.
// Latency: stall/flush are same-cycle combinational; backpressure: dmem_ready_i low holds IF..EX.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_mem_re_i,
  input  logic             ex_br_taken_i,
  input  logic             mem_req_i,
  input  logic             dmem_ready_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             flush_wb_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  mem_st_e           state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic rs1_hit, rs2_hit, load_use, mem_stall;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_req_i && !dmem_ready_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        // Ready in the final allowed cycle still completes the access.
        if (dmem_ready_i) begin
          state_d = IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    rs1_hit   = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit   = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
    load_use  = ex_mem_re_i && (ex_rd_addr_i != REG_ZERO) && (rs1_hit || rs2_hit);
    mem_stall = (state_q == IDLE && mem_req_i && !dmem_ready_i) ||
                (state_q == MEM_WAIT) || (state_q == ERR);
  end

  // Branch wins over load-use: the ID instruction is wrong-path and gets squashed anyway.
  always_comb begin
    stall_if_o = 1'b0;
    stall_id_o = 1'b0;
    stall_ex_o = 1'b0;
    flush_id_o = 1'b0;
    flush_ex_o = 1'b0;
    flush_wb_o = 1'b0;
    if (!rst) begin
      stall_if_o = 1'b0;
    end else if (mem_stall) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
      stall_ex_o = 1'b1;
      flush_wb_o = 1'b1;
    end else if (ex_br_taken_i) begin
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end else if (load_use) begin
      stall_if_o = 1'b1;
      flush_ex_o = 1'b1;
    end
  end

  assign mem_err_o = (state_q == ERR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_if_o),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush_id_o | flush_ex_o),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and 2-bit counters.
// Latency: n/a; backpressure: n/a.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic       id_rs1_used_i, id_rs2_used_i;
  logic       ex_mem_re_i, ex_br_taken_i, mem_req_i, dmem_ready_i;
  logic       stall_if_o, stall_id_o, stall_ex_o;
  logic       flush_id_o, flush_ex_o, flush_wb_o, mem_err_o;
  logic [1:0] stall_cnt_o, flush_cnt_o;
  logic [5:0] ctl;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_mem_re_i   (ex_mem_re_i),
    .ex_br_taken_i (ex_br_taken_i),
    .mem_req_i     (mem_req_i),
    .dmem_ready_i  (dmem_ready_i),
    .stall_if_o    (stall_if_o),
    .stall_id_o    (stall_id_o),
    .stall_ex_o    (stall_ex_o),
    .flush_id_o    (flush_id_o),
    .flush_ex_o    (flush_ex_o),
    .flush_wb_o    (flush_wb_o),
    .mem_err_o     (mem_err_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  // {stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_wb}
  assign ctl = {stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o, flush_wb_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1_addr_i = '0;
    id_rs2_addr_i = '0;
    id_rs1_used_i = 1'b0;
    id_rs2_used_i = 1'b0;
    ex_rd_addr_i  = '0;
    ex_mem_re_i   = 1'b0;
    ex_br_taken_i = 1'b0;
    mem_req_i     = 1'b0;
    dmem_ready_i  = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (ctl !== 6'b000000 || stall_cnt_o !== 2'd0 || flush_cnt_o !== 2'd0 || mem_err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: ctl=%b scnt=%0d fcnt=%0d err=%b want ctl=000000 0 0 0",
               ctl, stall_cnt_o, flush_cnt_o, mem_err_o);
    end
    mem_req_i    = 1'b1;
    dmem_ready_i = 1'b0;
    tick();
    tick();
    total++;
    if (stall_cnt_o !== 2'd2 || ctl !== 6'b111001) begin
      bad++;
      $display("FAIL reset_pre_wait: scnt=%0d ctl=%b want 2 111001", stall_cnt_o, ctl);
    end
    rst = 1'b0;
    #1;
    total++;
    if (ctl !== 6'b000000 || stall_cnt_o !== 2'd0 || flush_cnt_o !== 2'd0 || mem_err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: ctl=%b scnt=%0d fcnt=%0d err=%b want 000000 0 0 0",
               ctl, stall_cnt_o, flush_cnt_o, mem_err_o);
    end
    mem_req_i    = 1'b0;
    dmem_ready_i = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (ctl !== 6'b000000) begin
      bad++;
      $display("FAIL reset_state_idle: ctl=%b want 000000", ctl);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_re_i   = 1'b1;
    ex_rd_addr_i  = 5'd5;
    id_rs1_addr_i = 5'd5;
    id_rs1_used_i = 1'b0;
    id_rs2_addr_i = 5'd7;
    id_rs2_used_i = 1'b1;
    #1;
    total++;
    if (ctl !== 6'b000000) begin
      bad++;
      $display("FAIL lu_unused_rs1: ctl=%b want 000000", ctl);
    end
    id_rs2_addr_i = 5'd5;
    #1;
    total++;
    if (ctl !== 6'b100010) begin
      bad++;
      $display("FAIL lu_rs2_hit: ctl=%b want 100010", ctl);
    end
    tick();
    ex_mem_re_i  = 1'b0;
    ex_rd_addr_i = 5'd0;
    #1;
    total++;
    if (ctl !== 6'b000000 || stall_cnt_o !== 2'd1 || flush_cnt_o !== 2'd1) begin
      bad++;
      $display("FAIL lu_one_bubble: ctl=%b scnt=%0d fcnt=%0d want 000000 1 1",
               ctl, stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_x0();
    do_reset();
    ex_mem_re_i   = 1'b1;
    ex_rd_addr_i  = 5'd0;
    id_rs1_addr_i = 5'd0;
    id_rs1_used_i = 1'b1;
    #1;
    total++;
    if (ctl !== 6'b000000) begin
      bad++;
      $display("FAIL x0_no_hazard: ctl=%b want 000000", ctl);
    end
    tick();
    total++;
    if (stall_cnt_o !== 2'd0 || flush_cnt_o !== 2'd0) begin
      bad++;
      $display("FAIL x0_counters: scnt=%0d fcnt=%0d want 0 0", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_branch_lu();
    do_reset();
    ex_mem_re_i   = 1'b1;
    ex_rd_addr_i  = 5'd9;
    id_rs1_addr_i = 5'd9;
    id_rs1_used_i = 1'b1;
    ex_br_taken_i = 1'b1;
    #1;
    total++;
    if (ctl !== 6'b000110) begin
      bad++;
      $display("FAIL br_beats_lu: ctl=%b want 000110", ctl);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (flush_cnt_o !== 2'd1 || stall_cnt_o !== 2'd0) begin
      bad++;
      $display("FAIL br_counters: fcnt=%0d scnt=%0d want 1 0", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req_i     = 1'b1;
    dmem_ready_i  = 1'b0;
    ex_br_taken_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dmem_ready_i = 1'b1;
      #1;
      total++;
      if (ctl !== 6'b111001 || mem_err_o !== 1'b0) begin
        bad++;
        $display("FAIL memwait_cyc%0d: ctl=%b err=%b want 111001 0", c, ctl, mem_err_o);
      end
      tick();
    end
    #1;
    total++;
    if (ctl !== 6'b000110 || stall_cnt_o !== 2'd3) begin
      bad++;
      $display("FAIL memwait_release: ctl=%b scnt=%0d want 000110 3", ctl, stall_cnt_o);
    end
    tick();
    total++;
    if (flush_cnt_o !== 2'd1) begin
      bad++;
      $display("FAIL memwait_deferred_flush: fcnt=%0d want 1", flush_cnt_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req_i    = 1'b1;
    dmem_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (ctl !== 6'b111001 || mem_err_o !== 1'b0) begin
        bad++;
        $display("FAIL timeout_wait%0d: ctl=%b err=%b want 111001 0", c, ctl, mem_err_o);
      end
      tick();
    end
    total++;
    if (mem_err_o !== 1'b1 || ctl !== 6'b111001) begin
      bad++;
      $display("FAIL timeout_err: err=%b ctl=%b want 1 111001", mem_err_o, ctl);
    end
    mem_req_i     = 1'b0;
    dmem_ready_i  = 1'b1;
    ex_br_taken_i = 1'b1;
    tick();
    tick();
    total++;
    if (mem_err_o !== 1'b1 || ctl !== 6'b111001 || stall_cnt_o !== 2'd3 || flush_cnt_o !== 2'd0) begin
      bad++;
      $display("FAIL timeout_sticky: err=%b ctl=%b scnt=%0d fcnt=%0d want 1 111001 3 0",
               mem_err_o, ctl, stall_cnt_o, flush_cnt_o);
    end
    do_reset();
    total++;
    if (mem_err_o !== 1'b0 || ctl !== 6'b000000) begin
      bad++;
      $display("FAIL timeout_reset_clears: err=%b ctl=%b want 0 000000", mem_err_o, ctl);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_load_use();
    test_x0();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
